// File: rtl/wb_multi_arb_if.sv
// wb_multi_arb_if: lane-in / retire-out bundle of the writeback stage.
// master = producer lanes plus the register-file consumer, slave = the stage itself.
interface wb_multi_arb_if #(
   parameter int NCH   = 2,
   parameter int DBITS = 32,
   parameter int REGNO = 5,
   parameter int CSRNO = 12,
   parameter int LW    = (NCH > 1) ? $clog2(NCH) : 1
);
   logic                   flush;
   logic [NCH-1:0]         in_valid;
   logic [NCH-1:0]         in_ready;
   logic [NCH-1:0]         in_wr_reg;
   logic [NCH*REGNO-1:0]   in_rd;
   logic [NCH-1:0]         in_wr_csr;
   logic [NCH*CSRNO-1:0]   in_csrno;
   logic [NCH*DBITS-1:0]   in_val;
   logic [NCH*DBITS-1:0]   in_pc;
   logic                   wr_reg;
   logic [REGNO-1:0]       wregno;
   logic                   wr_csr;
   logic [CSRNO-1:0]       wcsrno;
   logic [DBITS-1:0]       regval;
   logic                   ret_valid;
   logic [DBITS-1:0]       ret_pc;
   logic [LW-1:0]          ret_lane;
   logic [DBITS-1:0]       ret_count;

   modport master (
      output flush, in_valid, in_wr_reg, in_rd, in_wr_csr, in_csrno, in_val, in_pc,
      input  in_ready, wr_reg, wregno, wr_csr, wcsrno, regval,
             ret_valid, ret_pc, ret_lane, ret_count
   );

   modport slave (
      input  flush, in_valid, in_wr_reg, in_rd, in_wr_csr, in_csrno, in_val, in_pc,
      output in_ready, wr_reg, wregno, wr_csr, wcsrno, regval,
             ret_valid, ret_pc, ret_lane, ret_count
   );
endinterface

// File: rtl/wb_multi_arb.sv
// wb_multi_arb: per-lane FIFOs feeding a round-robin retire arbiter.
// One entry retires per cycle; a popped entry passes a stage register and
// then the output register, so it is visible two edges after acceptance.
module wb_multi_arb #(
   parameter int NCH   = 2,
   parameter int DEPTH = 4,
   parameter int DBITS = 32,
   parameter int REGNO = 5,
   parameter int CSRNO = 12
) (
   input  logic            clk,
   input  logic            reset,
   wb_multi_arb_if.slave   bus
);
   localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic             wr_reg;
      logic [REGNO-1:0] rd;
      logic             wr_csr;
      logic [CSRNO-1:0] csrno;
      logic [DBITS-1:0] val;
      logic [DBITS-1:0] pc;
   } entry_t;

   entry_t           mem [NCH][DEPTH];
   logic [PW-1:0]    wr_ptr [NCH];
   logic [PW-1:0]    rd_ptr [NCH];
   logic [PW:0]      count  [NCH];
   logic [LW-1:0]    grant_ptr;

   logic             stg_valid;
   entry_t           stg;
   logic [LW-1:0]    stg_lane;

   entry_t           in_entry [NCH];
   logic [NCH-1:0]   push;
   logic [NCH-1:0]   pop_vec;
   logic             pop_valid;
   logic [LW-1:0]    pop_lane;
   logic [LW-1:0]    cand;

   // Ready is "not full" taken straight from the registered occupancy.
   for (genvar i = 0; i < NCH; i++) begin : g_ready
      assign bus.in_ready[i] = (count[i] != (PW+1)'(DEPTH));
   end

   // Unpack the flat lane buses and qualify pushes (flush blocks them).
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         in_entry[i] = '{wr_reg: bus.in_wr_reg[i],
                         rd:     bus.in_rd[i*REGNO +: REGNO],
                         wr_csr: bus.in_wr_csr[i],
                         csrno:  bus.in_csrno[i*CSRNO +: CSRNO],
                         val:    bus.in_val[i*DBITS +: DBITS],
                         pc:     bus.in_pc[i*DBITS +: DBITS]};
      end
      push = bus.in_valid & bus.in_ready & {NCH{~bus.flush}};
   end

   // Round-robin pick: first non-empty lane after the last granted one.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      pop_valid = 1'b0;
      pop_lane  = '0;
      cand      = '0;
      pop_vec   = '0;
      for (int k = 1; k <= NCH; k++) begin
         cand = LW'((int'(grant_ptr) + k) % NCH);
         if (!pop_valid && count[cand] != '0) begin
            pop_valid = 1'b1;
            pop_lane  = cand;
         end
      end
      for (int i = 0; i < NCH; i++) begin
         pop_vec[i] = pop_valid && (pop_lane == LW'(i));
      end
   end

   // Entry storage: write the tail of each lane that pushes.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; counts and pointers decide which slots are live.
      for (int i = 0; i < NCH; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= in_entry[i];
      end
   end

   // Pointers, occupancy, grant pointer, retire pipeline and outputs.
   always_ff @(posedge clk) begin
      // NOTE: all state uses non-blocking assignment so every reader sees pre-edge values.
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         grant_ptr     <= LW'(NCH - 1);
         stg_valid     <= 1'b0;
         stg           <= '0;
         stg_lane      <= '0;
         bus.ret_valid <= 1'b0;
         bus.wr_reg    <= 1'b0;
         bus.wregno    <= '0;
         bus.wr_csr    <= 1'b0;
         bus.wcsrno    <= '0;
         bus.regval    <= '0;
         bus.ret_pc    <= '0;
         bus.ret_lane  <= '0;
         bus.ret_count <= '0;
      end else if (bus.flush) begin
         // Drop everything buffered or in flight; grant pointer and counter survive.
         for (int i = 0; i < NCH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         stg_valid     <= 1'b0;
         stg           <= '0;
         stg_lane      <= '0;
         bus.ret_valid <= 1'b0;
         bus.wr_reg    <= 1'b0;
         bus.wregno    <= '0;
         bus.wr_csr    <= 1'b0;
         bus.wcsrno    <= '0;
         bus.regval    <= '0;
         bus.ret_pc    <= '0;
         bus.ret_lane  <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (push[i])    wr_ptr[i] <= wr_ptr[i] + PW'(1);
            if (pop_vec[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);
            count[i] <= count[i] + (PW+1)'(push[i]) - (PW+1)'(pop_vec[i]);
         end
         if (pop_valid) grant_ptr <= pop_lane;
         stg_valid <= pop_valid;
         stg       <= pop_valid ? mem[pop_lane][rd_ptr[pop_lane]] : '0;
         stg_lane  <= pop_valid ? pop_lane : '0;
         // Stage fields are zero when empty, so idle cycles drive zeros.
         bus.ret_valid <= stg_valid;
         bus.wr_reg    <= stg_valid && stg.wr_reg && (stg.rd != '0);
         bus.wregno    <= stg.rd;
         bus.wr_csr    <= stg_valid && stg.wr_csr;
         bus.wcsrno    <= stg.csrno;
         bus.regval    <= stg.val;
         bus.ret_pc    <= stg.pc;
         bus.ret_lane  <= stg_lane;
         if (stg_valid) bus.ret_count <= bus.ret_count + DBITS'(1);
      end
   end
endmodule
